// File: rtl/sdram_bscan_ctl.sv
// rtl/sdram_bscan_ctl.sv - boundary-scan sequencer for the SDRAM MD pad ring
//
// Runs one capture-shift-update pass over the MD boundary-scan chain per start
// request and returns the captured pad values in parallel.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             request a pass (accepted in IDLE or DONE only)
//   update_en         latched with start; 1 = pulse BScanUpdate at the end
//   load_data         latched with start; cell k ends up holding load_data[k]
//   mode_req          requested BScanMode level (frozen while busy)
//   bscan_out         chain tail (cell CHAIN_LEN-1 serial out)
//   bscan_in          serial data into cell 0
//   BScanShift/Clock/Mode/Update  pad chain controls
//   cap_data          captured pad values, cap_data[k] = cell k
//   busy, done        pass in progress / one-cycle completion pulse

module sdram_bscan_ctl #(
   parameter int CHAIN_LEN = 32,
   parameter int CNT_W     = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 update_en,
   input  logic [CHAIN_LEN-1:0] load_data,
   input  logic                 mode_req,
   input  logic                 bscan_out,
   output logic                 bscan_in,
   output logic                 BScanShift,
   output logic                 BScanClock,
   output logic                 BScanMode,
   output logic                 BScanUpdate,
   output logic [CHAIN_LEN-1:0] cap_data,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_SHIFT,
      S_UPDATE,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   state_t               state, state_n;
   logic                 phase, phase_n;   // 0 = scan clock low cycle, 1 = high cycle
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic                 accept;
   logic                 upd_q;
   logic [CHAIN_LEN-1:0] ld_q;
   logic                 shift_bit;

   always_comb begin
      state_n = state;
      phase_n = phase;
      cnt_n   = cnt;
      accept  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = S_CAPTURE;
               phase_n = 1'b0;
               accept  = 1'b1;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_CAPTURE: begin
            if (!phase) begin
               phase_n = 1'b1;
            end else begin
               state_n = S_SHIFT;
               phase_n = 1'b0;
               cnt_n   = '0;
            end
         end
         S_SHIFT: begin
            if (!phase) begin
               phase_n = 1'b1;
            end else if (cnt == LAST) begin
               state_n = upd_q ? S_UPDATE : S_DONE;
               phase_n = 1'b0;
            end else begin
               cnt_n   = cnt + 1'b1;
               phase_n = 1'b0;
            end
         end
         S_UPDATE: begin
            if (!phase) begin
               phase_n = 1'b1;
            end else begin
               state_n = S_DONE;
               phase_n = 1'b0;
            end
         end
         default: begin
            state_n = S_IDLE;
            phase_n = 1'b0;
         end
      endcase
   end

   // MSB first: bit i of the pass presents load_data[CHAIN_LEN-1-i].
   always_comb begin
      shift_bit = 1'b0;
      for (int k = 0; k < CHAIN_LEN; k++) begin
         if (cnt_n == CNT_W'(CHAIN_LEN - 1 - k)) shift_bit = ld_q[k];
      end
   end

   // Outputs are registered from the next state, so each output cycle
   // reflects the state the sequencer occupies in that same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         phase       <= 1'b0;
         cnt         <= '0;
         upd_q       <= 1'b0;
         ld_q        <= '0;
         bscan_in    <= 1'b0;
         BScanShift  <= 1'b0;
         BScanClock  <= 1'b0;
         BScanMode   <= 1'b0;
         BScanUpdate <= 1'b0;
         cap_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         cnt   <= cnt_n;
         if (accept) begin
            ld_q  <= load_data;
            upd_q <= update_en;
         end
         busy        <= (state_n == S_CAPTURE) || (state_n == S_SHIFT) || (state_n == S_UPDATE);
         done        <= (state_n == S_DONE);
         BScanShift  <= (state_n == S_SHIFT);
         BScanClock  <= ((state_n == S_CAPTURE) || (state_n == S_SHIFT)) && phase_n;
         BScanUpdate <= (state_n == S_UPDATE);
         if ((state_n == S_SHIFT) && !phase_n) bscan_in <= shift_bit;
         if ((state_n == S_IDLE) || (state_n == S_DONE)) BScanMode <= mode_req;
         // End of a shift low cycle: the tail holds the cell that bit i lands on.
         if ((state == S_SHIFT) && !phase) begin
            for (int k = 0; k < CHAIN_LEN; k++) begin
               if (cnt == CNT_W'(CHAIN_LEN - 1 - k)) cap_data[k] <= bscan_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_bscan_ctl.sv
// tb/tb_sdram_bscan_ctl.sv - self-checking bench for sdram_bscan_ctl

module tb_sdram_bscan_ctl;

   localparam int L = 32;
   localparam logic [L-1:0] PAD = 32'h1234_5678;

   logic         clk = 1'b0;
   logic         reset, start, update_en, mode_req;
   logic [L-1:0] load_data;
   logic         bscan_out, bscan_in;
   logic         BScanShift, BScanClock, BScanMode, BScanUpdate;
   logic [L-1:0] cap_data;
   logic         busy, done;

   logic [L-1:0] cells = '0;
   assign bscan_out = cells[L-1];

   sdram_bscan_ctl #(.CHAIN_LEN(L), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .update_en(update_en),
      .load_data(load_data), .mode_req(mode_req), .bscan_out(bscan_out),
      .bscan_in(bscan_in), .BScanShift(BScanShift), .BScanClock(BScanClock),
      .BScanMode(BScanMode), .BScanUpdate(BScanUpdate), .cap_data(cap_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [L-1:0] cap;
      logic [L-1:0] cells;
      int           done_cyc;
      bit           upd;
   } exp_t;
   exp_t sb[$];

   // Chain model and pass monitor.
   logic         prev_clk = 1'b0;
   int           rises = 0;
   int           upd_cycles = 0;
   bit           snap_taken = 0;
   logic [L-1:0] upd_snap = '0;

   always @(negedge clk) begin
      if (reset) begin
         rises = 0; upd_cycles = 0; snap_taken = 0; prev_clk = 1'b0;
      end else begin
         if (BScanClock && !prev_clk) begin
            rises++;
            if (!BScanShift) cells = PAD;
            else             cells = {cells[L-2:0], bscan_in};
         end
         prev_clk = BScanClock;
         if (BScanUpdate) begin
            upd_cycles++;
            if (!snap_taken) begin upd_snap = cells; snap_taken = 1; end
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("cap_data", cap_data, e.cap);
               check("done_cycle", cyc, e.done_cyc);
               check("clock_rises", rises, 33);
               check("update_cycles", upd_cycles, e.upd ? 2 : 0);
               if (e.upd) check("cells_at_update", upd_snap, e.cells);
            end
            rises = 0; upd_cycles = 0; snap_taken = 0;
         end
      end
   end

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_shift"}, BScanShift, 0);
      check({pfx, "_clock"}, BScanClock, 0);
      check({pfx, "_mode"}, BScanMode, 0);
      check({pfx, "_update"}, BScanUpdate, 0);
      check({pfx, "_bscan_in"}, bscan_in, 0);
      check({pfx, "_cap_data"}, cap_data, 0);
   endtask

   // Called at a negedge: drives start during the current cycle (cycle 0).
   task automatic do_start(input logic [L-1:0] ld, input bit upd, output int t0);
      exp_t e;
      t0 = cyc;
      start = 1'b1; load_data = ld; update_en = upd;
      e.cap = PAD; e.cells = ld; e.done_cyc = t0 + (upd ? 69 : 67); e.upd = upd;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0; load_data = ~ld; update_en = ~upd;
      check("capture_busy", busy, 1);
      check("capture_clock", BScanClock, 0);
      check("capture_shift", BScanShift, 0);
   endtask

   task automatic wait_done(input int t0, input bit extra);
      int mode_bad = 0;
      bit seen = 0;
      for (int n = 0; n < 150 && !seen; n++) begin
         if (extra && cyc == t0 + 10) begin
            start = 1'b1; load_data = 32'hFFFF_FFFF; update_en = 1'b0;
         end
         if (extra && cyc == t0 + 30) mode_req = 1'b0;
         @(negedge clk);
         start = 1'b0;
         if (extra && busy && BScanMode !== 1'b1) mode_bad++;
         if (done) seen = 1;
      end
      check("done_seen", seen, 1);
      if (extra) begin
         check("mode_frozen", mode_bad, 0);
         check("mode_at_done", BScanMode, 0);
      end
   endtask

   initial begin
      int t0;
      int dcount;
      reset = 1'b1; start = 1'b0; update_en = 1'b0; load_data = '0; mode_req = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      mode_req = 1'b1;
      repeat (2) @(negedge clk);
      check("mode_idle", BScanMode, 1);

      // Full pass with ignored mid-pass start and mode toggle.
      do_start(32'hA5A5_F00F, 1'b1, t0);
      wait_done(t0, 1'b1);

      // Back-to-back no-update pass, started in the DONE cycle.
      do_start(32'hA5A5_F00F, 1'b0, t0);
      wait_done(t0, 1'b0);

      // Back-to-back again, then reset in cycle 20 of the next pass.
      do_start(32'h3C3C_00FF, 1'b1, t0);
      wait_done(t0, 1'b0);
      do_start(32'h0F0F_1234, 1'b1, t0);
      while (cyc < t0 + 20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      reset = 1'b0;
      void'(sb.pop_back());
      dcount = 0;
      repeat (100) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("no_done_after_reset", dcount, 0);

      do_start(32'h5A5A_5A5A, 1'b1, t0);
      wait_done(t0, 1'b0);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_bscan_ctl.md
# sdram_bscan_ctl

Boundary-scan sequencer for the SDRAM MD[31:0] pad ring. It drives the pad chain's shift, clock, mode and update controls and feeds the serial input at cell 0. It runs one capture-shift-update pass per request and returns the captured pad values in parallel. It sits directly upstream of the I/O pad subsystem, which consumes BScanShift/BScanClock/BScanMode/BScanUpdate and bscan_in, and returns the chain tail as bscan_out.

## Interface
- CHAIN_LEN, 32, number of boundary-scan cells in the chain (one per MD pad)
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN

- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- start  in  1  request one scan pass; single-cycle pulse
- update_en  in  1  sampled with start; 1 = pulse BScanUpdate at the end of the pass
- load_data  in  CHAIN_LEN  pattern to shift in, sampled with start; after the pass, cell k holds load_data[k]
- mode_req  in  1  requested BScanMode level
- bscan_out  in  1  chain tail, cell CHAIN_LEN-1 serial out
- bscan_in  out  1  serial data into cell 0
- BScanShift  out  1  1 = shift, 0 = capture
- BScanClock  out  1  scan clock, generated at clk/2 during a pass
- BScanMode  out  1  pad boundary-scan mode
- BScanUpdate  out  1  update strobe
- cap_data  out  CHAIN_LEN  captured pad values; cap_data[k] = cell k
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse

## Operation
- All outputs are registered. On reset every output is 0, including cap_data, and the state is IDLE.
- States and transitions:
  - IDLE: wait for start.
  - CAPTURE: 2 cycles.
  - SHIFT: 2×CHAIN_LEN cycles.
  - UPDATE: 2 cycles; skipped when the latched update_en = 0.
  - DONE: 1 cycle, then IDLE.
- start is accepted only in IDLE or DONE; it is ignored in any other state. On accept, load_data and update_en are latched.
- BScanMode follows mode_req, registered, only while in IDLE or DONE. It is frozen for the whole pass.
- CAPTURE:
  - BScanShift = 0.
  - BScanClock is 0 for one cycle, then 1 for one cycle; this is the pads' capture edge.
- SHIFT, bit i (i = 0..CHAIN_LEN-1), MSB first:
  - Low cycle: BScanShift = 1, BScanClock = 0, bscan_in = load_data[CHAIN_LEN-1-i]. At the end of this cycle, bscan_out is sampled into cap_data[CHAIN_LEN-1-i].
  - High cycle: BScanClock = 1; bscan_in and BScanShift are held.
- BScanShift and bscan_in change only in cycles where BScanClock = 0.
- UPDATE: BScanShift = 0, BScanClock = 0, BScanUpdate = 1 for both cycles.
- DONE: done = 1, busy = 0, cap_data is final.
  - cap_data holds its value until the next accepted start.
  - cap_data may change during a pass.
- busy = 1 in CAPTURE, SHIFT and UPDATE.
- The bit counter counts 0..CHAIN_LEN-1 with no wrap. It is cleared on entry to SHIFT.

## Timing
- Numbering: start is seen at edge 0; cycle n is the cycle after edge n.
- CAPTURE occupies cycles 1–2; BScanClock is high in cycle 2.
- SHIFT occupies cycles 3 to 2·CHAIN_LEN+2.
- UPDATE occupies cycles 2·CHAIN_LEN+3 and 2·CHAIN_LEN+4.
- done appears in cycle 2·CHAIN_LEN+5 with update, or 2·CHAIN_LEN+3 without. For CHAIN_LEN = 32 that is cycle 69 or 67.
- Back-to-back: a start in the DONE cycle begins CAPTURE in the next cycle, with no idle gap.
- Reset mid-pass: at the next edge all outputs are 0 and the state is IDLE. No done pulse is produced and cap_data is cleared.
- Simultaneous start and reset: reset wins.

## Test plan
- Reset release:
  - Stimulus: assert reset for 2 cycles.
  - Response: every output is 0, including cap_data = 0 and BScanMode = 0.
- Full pass, CHAIN_LEN = 32:
  - Bench model: a 32-bit chain that captures pad vector 0x12345678 on a BScanClock rise with BScanShift = 0, and shifts on a rise with BScanShift = 1.
  - Stimulus: load_data = 0xA5A5F00F, update_en = 1.
  - Response: cap_data = 0x12345678; model cells = 0xA5A5F00F when BScanUpdate is first high; exactly 33 BScanClock rises; done in cycle 69.
- No-update pass:
  - Stimulus: update_en = 0, otherwise as the full pass.
  - Response: BScanUpdate never asserts; done in cycle 67.
- start handling:
  - Stimulus: start pulsed in cycle 10; later, start pulsed in the DONE cycle.
  - Response: the cycle-10 start is ignored and the pass timing is unchanged. The DONE-cycle start produces CAPTURE in the next cycle.
- Mid-pass reset:
  - Stimulus: reset in cycle 20.
  - Response: all outputs are 0 at cycle 21; no done follows; a new start afterwards completes normally.
- Mode freeze:
  - Stimulus: mode_req = 1 in IDLE, then toggled at cycle 30 of a pass.
  - Response: BScanMode stays 1 throughout the pass and follows mode_req again from the DONE cycle.
